sha512_round_ctrl: RTL

// - Sequencer for the one-round sha512_compression datapath: accepts 1024-bit message blocks, runs 80 rounds

---
 rtl/sha512_pkg.sv | 70 +++++++
 rtl/sha512_msg_sched.sv | 31 +++
 rtl/sha512_round_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sha512_pkg.sv
// Shared SHA-512 constants, schedule sigma functions and controller state type.
package sha512_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_FINAL = 3'd3,
      ST_OUT   = 3'd4
   } sha512_state_t;

   localparam int unsigned ROUNDS = 80;

   localparam logic [63:0] K [0:79] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
   };

   localparam logic [63:0] IV [0:7] = '{
      64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
      64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
   };

   // H0 lands in the most significant word, matching the digest packing
   function automatic logic [511:0] iv_block();
      logic [511:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) v[511-64*i -: 64] = IV[i];
      return v;
   endfunction

   function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [63:0] sigma0(input logic [63:0] x);
      return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
   endfunction

   function automatic logic [63:0] sigma1(input logic [63:0] x);
      return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
   endfunction

   // Eight independent 64-bit adds; carries never cross word boundaries
   function automatic logic [511:0] h_add(input logic [511:0] a, input logic [511:0] b);
      logic [511:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[64*i +: 64] = a[64*i +: 64] + b[64*i +: 64];
      return r;
   endfunction

endpackage

// File: rtl/sha512_msg_sched.sv
// SHA-512 message schedule: 16-word sliding window, o_wt is always W[t].
module sha512_msg_sched
   import sha512_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_load,
   input  logic          i_shift,
   input  logic [1023:0] i_blk,
   output logic [63:0]   o_wt
);

   logic [63:0] r_win [0:15];
   logic [63:0] w_next;

   // r_win[0] = W[t], so the incoming word is W[t+16]
   assign w_next = sigma1(r_win[14]) + r_win[9] + sigma0(r_win[1]) + r_win[0];
   assign o_wt   = r_win[0];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < 16; i++) r_win[i] <= '0;
      end else if (i_load) begin
         for (int i = 0; i < 16; i++) r_win[i] <= i_blk[1023-64*i -: 64];
      end else if (i_shift) begin
         for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
         r_win[15] <= w_next;
      end
   end

endmodule

// File: rtl/sha512_round_ctrl.sv
// Sequences 80 SHA-512 rounds through an external one-round datapath and chains the digest.
//   state    | meaning
//   ST_IDLE  | blk_ready=1, waiting for a message block
//   ST_ISSUE | present W[t]/K[t]/working, schedule cmp_start
//   ST_WAIT  | cmp_start pulse, then wait for cmp_done or timeout
//   ST_FINAL | H += working
//   ST_OUT   | digest_valid=1 until digest_ready
module sha512_round_ctrl
   import sha512_pkg::*;
#(
   parameter int unsigned DONE_TIMEOUT = 255
)(
   input  logic          clk,
   input  logic          sha512_reset,
   input  logic          blk_valid,
   output logic          blk_ready,
   input  logic          blk_first,
   input  logic [1023:0] blk_data,
   output logic          digest_valid,
   input  logic          digest_ready,
   output logic [511:0]  digest,
   output logic          cmp_start,
   output logic [63:0]   cmp_wi,
   output logic [63:0]   cmp_ki,
   output logic [511:0]  cmp_state_o,
   input  logic [511:0]  cmp_state_i,
   input  logic          cmp_done,
   output logic          err
);

   localparam logic [15:0] TMO_INIT = 16'(DONE_TIMEOUT);
   localparam logic [6:0]  LAST_T   = 7'(ROUNDS - 1);

   sha512_state_t r_state;
   logic [6:0]    r_t;
   logic [15:0]   r_tmo;
   logic [511:0]  r_h;
   logic [511:0]  r_work;
   logic          r_cmp_start;
   logic          r_digest_valid;
   logic          r_blk_ready;
   logic          r_err;

   logic          w_accept;
   logic          w_done;
   logic [63:0]   w_wt;

   assign w_accept = (r_state == ST_IDLE) && blk_valid && r_blk_ready;
   // A done coinciding with our own start pulse can only be a stale one
   assign w_done   = (r_state == ST_WAIT) && cmp_done && !r_cmp_start;

   sha512_msg_sched u_sched (
      .i_clk   (clk),
      .i_rst   (sha512_reset),
      .i_load  (w_accept),
      .i_shift (w_done),
      .i_blk   (blk_data),
      .o_wt    (w_wt)
   );

   assign blk_ready    = r_blk_ready;
   assign digest_valid = r_digest_valid;
   assign digest       = r_h;
   assign cmp_start    = r_cmp_start;
   assign cmp_wi       = w_wt;
   assign cmp_ki       = K[r_t];
   assign cmp_state_o  = r_work;
   assign err          = r_err;

   always_ff @(posedge clk) begin
      if (sha512_reset) begin
         r_state        <= ST_IDLE;
         r_t            <= '0;
         r_tmo          <= '0;
         r_h            <= iv_block();
         r_work         <= '0;
         r_cmp_start    <= 1'b0;
         r_digest_valid <= 1'b0;
         r_blk_ready    <= 1'b1;
         r_err          <= 1'b0;
      end else begin
         r_cmp_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (blk_first) r_h <= iv_block();
                  r_work      <= blk_first ? iv_block() : r_h;
                  r_t         <= '0;
                  r_blk_ready <= 1'b0;
                  r_state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_cmp_start <= 1'b1;
               r_tmo       <= TMO_INIT;
               r_state     <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_done) begin
                  r_work <= cmp_state_i;
                  if (r_t == LAST_T) begin
                     r_state <= ST_FINAL;
                  end else begin
                     r_t     <= r_t + 7'd1;
                     r_state <= ST_ISSUE;
                  end
               end else if (DONE_TIMEOUT != 0) begin
                  if (r_tmo == 16'd1) begin
                     r_err       <= 1'b1;
                     r_blk_ready <= 1'b1;
                     r_state     <= ST_IDLE;
                  end else begin
                     r_tmo <= r_tmo - 16'd1;
                  end
               end
            end
            ST_FINAL: begin
               r_h            <= h_add(r_h, r_work);
               r_digest_valid <= 1'b1;
               r_state        <= ST_OUT;
            end
            ST_OUT: begin
               if (digest_ready) begin
                  r_digest_valid <= 1'b0;
                  r_blk_ready    <= 1'b1;
                  r_state        <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
